enigma_key_arbiter: RTL and testbench

Shares the single Enigma encoding path (`machine_controller` plus rotors/reflector) between two key sources: the PS/2 keyboard decoder (requester 0) and the UART receiver (requester 1). Grants one request at a time round-robin, normalises and validates the ASCII key, issues a one-cycle `key_ok` with a stable `key`, waits for the controller's `save_history` pulse, and returns the encoded letter to the requester with a tag. A watchdog aborts a transaction if `save_history` never arrives.

---
 rtl/enigma_key_arbiter.sv | 173 +++++++++++++++++
 tb/tb_enigma_key_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_key_arbiter.sv
// rtl/enigma_key_arbiter.sv - round-robin arbiter sharing the Enigma encoding path between keyboard and UART
module enigma_key_arbiter #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [7:0]  req_key0,
  input  logic [7:0]  req_key1,
  output logic [1:0]  req_ready,
  output logic [7:0]  key,
  output logic        key_ok,
  input  logic [4:0]  after,
  input  logic        save_history,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [7:0]  resp_char,
  output logic        resp_err,
  output logic        busy,
  output logic [15:0] char_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              win_q, win_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [1:0]        req_ready_q, req_ready_d;
  logic [7:0]        key_q, key_d;
  logic              key_ok_q, key_ok_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;
  logic [7:0]        resp_char_q, resp_char_d;
  logic              resp_err_q, resp_err_d;
  logic              busy_q, busy_d;
  logic [15:0]       char_count_q, char_count_d;

  logic              any_req;
  logic              w;
  logic [7:0]        raw_key;
  logic [7:0]        norm_key;
  logic              key_valid;
  logic              grant_en;

  // Pick the candidate winner and normalise its key to uppercase
  always_comb begin
    any_req   = |req_valid;
    w         = (req_valid == 2'b10) || ((req_valid == 2'b11) && rr_ptr_q);
    raw_key   = w ? req_key1 : req_key0;
    norm_key  = ((raw_key >= 8'h61) && (raw_key <= 8'h7A)) ? (raw_key - 8'd32) : raw_key;
    key_valid = (norm_key >= 8'h41) && (norm_key <= 8'h5A);
  end

  // Next-state and registered-output logic of the grant/issue/wait/respond FSM
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    win_d        = win_q;
    wd_d         = wd_q;
    req_ready_d  = 2'b00;
    key_d        = key_q;
    key_ok_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_char_d  = resp_char_q;
    resp_err_d   = 1'b0;
    char_count_d = char_count_q;
    grant_en     = 1'b0;

    case (state_q)
      IDLE: begin
        grant_en = 1'b1;
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (save_history) begin
          resp_valid_d = 1'b1;
          resp_id_d    = win_q;
          resp_char_d  = 8'd65 + {3'b000, after};
          char_count_d = char_count_q + 16'd1;
          state_d      = RESP;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          resp_valid_d = 1'b1;
          resp_id_d    = win_q;
          resp_char_d  = 8'd0;
          resp_err_d   = 1'b1;
          state_d      = RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        if (!resp_valid_q) begin
          // Entered straight from a grant with a rejected key: emit the error now
          resp_valid_d = 1'b1;
          resp_id_d    = win_q;
          resp_char_d  = 8'd0;
          resp_err_d   = 1'b1;
        end else begin
          // Response already on the bus this cycle, so a new grant may overlap it
          grant_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_en && any_req) begin
      req_ready_d[w] = 1'b1;
      win_d          = w;
      rr_ptr_d       = ~w;
      if (key_valid) begin
        key_d    = norm_key;
        key_ok_d = 1'b1;
        state_d  = ISSUE;
      end else begin
        state_d  = RESP;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      win_q        <= 1'b0;
      wd_q         <= '0;
      req_ready_q  <= 2'b00;
      key_q        <= 8'd0;
      key_ok_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_char_q  <= 8'd0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      char_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      win_q        <= win_d;
      wd_q         <= wd_d;
      req_ready_q  <= req_ready_d;
      key_q        <= key_d;
      key_ok_q     <= key_ok_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_char_q  <= resp_char_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      char_count_q <= char_count_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign key        = key_q;
  assign key_ok     = key_ok_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_char  = resp_char_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;
  assign char_count = char_count_q;

endmodule

// File: tb/tb_enigma_key_arbiter.sv
// tb/tb_enigma_key_arbiter.sv - scoreboard bench for enigma_key_arbiter
module tb_enigma_key_arbiter;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [7:0]  req_key0;
  logic [7:0]  req_key1;
  logic [1:0]  req_ready;
  logic [7:0]  key;
  logic        key_ok;
  logic [4:0]  after;
  logic        save_history;
  logic        resp_valid;
  logic        resp_id;
  logic [7:0]  resp_char;
  logic        resp_err;
  logic        busy;
  logic [15:0] char_count;

  enigma_key_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_key0(req_key0), .req_key1(req_key1),
    .req_ready(req_ready), .key(key), .key_ok(key_ok), .after(after), .save_history(save_history),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_char(resp_char), .resp_err(resp_err),
    .busy(busy), .char_count(char_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [7:0]  ch;
    logic        err;
    logic [15:0] cnt;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          prev_grant = -100;
  bit          gap_en = 0;
  int          key_ok_cnt = 0;
  int          resp_cnt = 0;
  int          mcnt = 0;
  bit          model_en = 1;
  bit          model_drove = 0;
  logic [4:0]  model_after = 5'd0;
  logic [15:0] exp_count = 16'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] norm(input logic [7:0] k);
    if ((k >= 8'h61) && (k <= 8'h7A)) return k - 8'd32;
    return k;
  endfunction

  function automatic bit is_letter(input logic [7:0] k);
    logic [7:0] n;
    n = norm(k);
    return (n >= 8'h41) && (n <= 8'h5A);
  endfunction

  task automatic push_exp(input logic id, input logic [7:0] k);
    exp_t e;
    e.id = id;
    if (!is_letter(k)) begin
      e.ch = 8'd0; e.err = 1'b1; e.cnt = exp_count; e.lat = 1;
    end else if (model_en) begin
      exp_count = exp_count + 16'd1;
      e.ch = 8'd65 + {3'b000, model_after}; e.err = 1'b0; e.cnt = exp_count; e.lat = 5;
    end else begin
      e.ch = 8'd0; e.err = 1'b1; e.cnt = exp_count; e.lat = TIMEOUT + 1;
    end
    sb_q.push_back(e);
  endtask

  task automatic send(input int id, input logic [7:0] k);
    int n;
    n = 0;
    if (id == 0) req_key0 = k; else req_key1 = k;
    req_valid[id] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[id] && n < 50);
    check_eq("grant_seen", {31'd0, req_ready[id]}, 1);
    req_valid[id] = 1'b0;
  endtask

  task automatic hold_both(input int n);
    int g;
    int t;
    g = 0;
    t = 0;
    req_valid = 2'b11;
    while (g < n && t < 100) begin
      @(negedge clk);
      t++;
      if (req_ready != 2'b00) g++;
    end
    check_eq("hold_grants", g, n);
    req_valid = 2'b00;
  endtask

  task automatic wait_drain(input int max);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < max) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain", sb_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string pfx);
    check_eq({pfx, "_req_ready"}, {30'd0, req_ready}, 0);
    check_eq({pfx, "_key"}, {24'd0, key}, 0);
    check_eq({pfx, "_key_ok"}, {31'd0, key_ok}, 0);
    check_eq({pfx, "_resp_valid"}, {31'd0, resp_valid}, 0);
    check_eq({pfx, "_resp_id"}, {31'd0, resp_id}, 0);
    check_eq({pfx, "_resp_char"}, {24'd0, resp_char}, 0);
    check_eq({pfx, "_resp_err"}, {31'd0, resp_err}, 0);
    check_eq({pfx, "_busy"}, {31'd0, busy}, 0);
    check_eq({pfx, "_char_count"}, {16'd0, char_count}, 0);
  endtask

  // Monitor, controller model and scoreboard comparison, all on the falling edge
  initial begin
    logic       gid;
    logic [7:0] k;
    exp_t       e;
    forever begin
      @(negedge clk);
      cyc++;
      if (model_drove) begin
        save_history = 1'b0;
        model_drove = 1'b0;
      end
      if (!reset) begin
        mcnt = 0;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          save_history = 1'b1;
          after = model_after;
          model_drove = 1'b1;
        end
      end
      if (req_ready != 2'b00) begin
        check_eq("ready_onehot", $countones(req_ready), 1);
        if (gap_en) check_eq("grant_gap_ge6", {31'd0, (cyc - prev_grant) >= 6}, 1);
        prev_grant = cyc;
        gid = req_ready[1];
        k = gid ? req_key1 : req_key0;
        check_eq("key_ok_on_grant", {31'd0, key_ok}, {31'd0, is_letter(k)});
        if (is_letter(k)) check_eq("key", {24'd0, key}, {24'd0, norm(k)});
        check_eq("busy_on_grant", {31'd0, busy}, 1);
      end
      if (key_ok) begin
        key_ok_cnt++;
        if (model_en) mcnt = 4;
      end
      if (resp_valid) begin
        resp_cnt++;
        check_eq("resp_expected", {31'd0, sb_q.size() != 0}, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_eq("resp_id", {31'd0, resp_id}, {31'd0, e.id});
          check_eq("resp_char", {24'd0, resp_char}, {24'd0, e.ch});
          check_eq("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          check_eq("char_count", {16'd0, char_count}, {16'd0, e.cnt});
          check_eq("latency", cyc - prev_grant, e.lat);
        end
      end
    end
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time bound expired");
  end

  // Stimulus sequence
  initial begin
    int rc;
    reset = 1'b0;
    req_valid = 2'b00;
    req_key0 = 8'd0;
    req_key1 = 8'd0;
    after = 5'd0;
    save_history = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // Both requesters held from reset: grants alternate 0,1,0,1
    model_after = 5'd3;
    req_key0 = "A";
    req_key1 = "B";
    push_exp(1'b0, "A"); push_exp(1'b1, "B"); push_exp(1'b0, "A"); push_exp(1'b1, "B");
    prev_grant = -100;
    gap_en = 1;
    hold_both(4);
    gap_en = 0;
    wait_drain(40);

    // Lowercase keyboard key, nominal encode
    model_after = 5'd7;
    key_ok_cnt = 0;
    push_exp(1'b0, "h");
    send(0, "h");
    wait_drain(40);
    check_eq("t1_key_ok_pulses", key_ok_cnt, 1);

    // Invalid UART key: immediate error, no key_ok
    key_ok_cnt = 0;
    push_exp(1'b1, "5");
    send(1, "5");
    wait_drain(40);
    check_eq("invalid_no_key_ok", key_ok_cnt, 0);

    // Watchdog timeout, then a late save_history in IDLE
    model_en = 0;
    push_exp(1'b0, "q");
    send(0, "q");
    wait_drain(40);
    save_history = 1'b1;
    after = 5'd5;
    @(negedge clk);
    save_history = 1'b0;
    rc = resp_cnt;
    repeat (10) @(negedge clk);
    check_eq("late_save_no_resp", resp_cnt, rc);
    check_eq("late_save_idle", {31'd0, busy}, 0);
    model_en = 1;

    // Reset during WAIT abandons the transaction
    send(0, "c");
    repeat (3) @(negedge clk);
    check_eq("wait_busy", {31'd0, busy}, 1);
    #2;
    reset = 1'b0;
    #1;
    check_zero_outputs("midreset");
    exp_count = 16'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    model_after = 5'd25;
    req_key0 = "Z";
    req_key1 = "Z";
    push_exp(1'b0, "Z"); push_exp(1'b1, "Z");
    hold_both(2);
    wait_drain(40);

    // char_count wrap from 0xFFFF
    force dut.char_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.char_count_q;
    @(negedge clk);
    check_eq("preload", {16'd0, char_count}, 32'h0000FFFF);
    exp_count = 16'hFFFF;
    model_after = 5'd0;
    push_exp(1'b1, "a");
    send(1, "a");
    wait_drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
